// File: rtl/aca_pkg.sv
// Shared types and default geometry for the ACA error-recovery stage.
package aca_pkg;

    localparam int ACA_WIDTH  = 16;
    localparam int ACA_WINDOW = 8;
    localparam int ACA_CHUNK  = 4;
    localparam int ACA_NCHUNK = ACA_WIDTH / ACA_CHUNK;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIX  = 2'd1,
        DONE = 2'd2
    } aca_state_e;

endpackage

// File: rtl/aca_err_detect.sv
// Combinational detector: flags operands whose carry chain outruns the ACA
// speculation window (a generate followed by WINDOW consecutive propagates).
module aca_err_detect
    import aca_pkg::*;
#(
    parameter int WIDTH  = ACA_WIDTH,
    parameter int WINDOW = ACA_WINDOW
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             err
);

    always_comb begin
        err = 1'b0;
        for (int j = 0; j + WINDOW <= WIDTH - 1; j++) begin
            if ((a[j] & b[j]) && (&(a[j+1 +: WINDOW] ^ b[j+1 +: WINDOW]))) begin
                err = 1'b1;
            end
        end
    end

endmodule

// File: rtl/aca_error_recovery.sv
// ACA error-recovery stage: forwards correct speculative sums, otherwise
// re-adds CHUNK bits per cycle. Optional saturating counter: ACA_ERR_COUNT_EN.
module aca_error_recovery
    import aca_pkg::*;
#(
    parameter int WIDTH  = ACA_WIDTH,
    parameter int WINDOW = ACA_WINDOW,
    parameter int CHUNK  = ACA_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] approx_sum,
    input  logic             approx_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             err_flag,
`ifdef ACA_ERR_COUNT_EN
    output logic [15:0]      err_count,
`endif
    output logic [1:0]       dbg_state
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    aca_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             cout_q, cout_d, err_flag_q, err_flag_d, carry_q, carry_d;
    logic [KW-1:0]    k_q, k_d;
    logic             det_err, accept, last_chunk;
    logic [CHUNK:0]   chunk_sum;

    aca_err_detect #(.WIDTH(WIDTH), .WINDOW(WINDOW)) u_det (
        .a   (a),
        .b   (b),
        .err (det_err)
    );

    // Valid/ready: a transfer happens on a rising edge where valid && ready;
    // in_ready follows out_ready combinationally so DONE can hand off and
    // accept in the same edge.
    assign in_ready   = rst_n && ((state_q == IDLE) || (state_q == DONE && out_ready));
    assign accept     = in_valid && in_ready;
    assign chunk_sum  = {1'b0, a_q[k_q*CHUNK +: CHUNK]} + {1'b0, b_q[k_q*CHUNK +: CHUNK]}
                      + {{CHUNK{1'b0}}, carry_q};
    assign last_chunk = (k_q == KW'(NCHUNK - 1));

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        sum_d      = sum_q;
        cout_d     = cout_q;
        err_flag_d = err_flag_q;
        carry_d    = carry_q;
        k_d        = k_q;

        case (state_q)
            FIX: begin
                sum_d[k_q*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
                carry_d                   = chunk_sum[CHUNK];
                k_d                       = KW'(k_q + 1'b1);
                if (last_chunk) begin
                    cout_d  = chunk_sum[CHUNK];
                    k_d     = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready && !in_valid) begin
                    state_d = IDLE;
                end
            end
            default: ;
        endcase

        // Accept only happens in IDLE or DONE, so it never collides with FIX.
        if (accept) begin
            if (det_err) begin
                a_d        = a;
                b_d        = b;
                carry_d    = 1'b0;
                k_d        = '0;
                err_flag_d = 1'b1;
                state_d    = FIX;
            end else begin
                sum_d      = approx_sum;
                cout_d     = approx_cout;
                err_flag_d = 1'b0;
                state_d    = DONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            err_flag_q <= 1'b0;
            carry_q    <= 1'b0;
            k_q        <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sum_q      <= sum_d;
            cout_q     <= cout_d;
            err_flag_q <= err_flag_d;
            carry_q    <= carry_d;
            k_q        <= k_d;
        end
    end

`ifdef ACA_ERR_COUNT_EN
    logic [15:0] err_count_q, err_count_d;

    always_comb begin
        err_count_d = err_count_q;
        if (accept && det_err && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`endif

    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign err_flag  = err_flag_q;
    assign dbg_state = state_q;

endmodule
